// File: rtl/keccak_padder_mr.sv
// Multi-rate Keccak input padder: packs 64-bit words into SHA3 rate blocks with pad10*1.
// Define KECCAK_PADDER_XOF_EN to add the xof input (SHAKE128/256 rates, 0x1F domain byte).
module keccak_padder_mr (
   input  logic          clk,
   input  logic          reset,
   input  logic [63:0]   in,
   input  logic          in_ready,
   input  logic          is_last,
   input  logic [2:0]    byte_num,
   input  logic [1:0]    mode,
`ifdef KECCAK_PADDER_XOF_EN
   input  logic          xof,
`endif
   output logic          buffer_full,
   output logic [1343:0] out,
   output logic          out_ready,
   output logic          out_last,
   input  logic          f_ack
);
   localparam logic [7:0] DSEP = 8'h06;
`ifdef KECCAK_PADDER_XOF_EN
   localparam logic [7:0] XOF_DSEP = 8'h1F;
   localparam int MAX_WORDS = 21;
`else
   localparam int MAX_WORDS = 18;
`endif
   localparam int OUT_WORDS = 21;

   typedef enum logic {FILL, FULL} state_t;
   state_t state_q, state_d;

   logic [63:0] blk   [MAX_WORDS];
   logic [63:0] blk_d [MAX_WORDS];
   logic [4:0]  cnt, cnt_inc, rate_q, rate_sel, rate_eff;
   logic [7:0]  dsep_eff;
   logic [63:0] keep_mask, last_word;
   logic        accept, block_done;

   // Rate (in words) selected by mode; only used when a block starts at cnt=0
   always_comb begin
      rate_sel = 5'd9;
      case (mode)
         2'd0:    rate_sel = 5'd18;
         2'd1:    rate_sel = 5'd17;
         2'd2:    rate_sel = 5'd13;
         default: rate_sel = 5'd9;
      endcase
`ifdef KECCAK_PADDER_XOF_EN
      if (xof && mode == 2'd0) rate_sel = 5'd21;
`endif
   end

`ifdef KECCAK_PADDER_XOF_EN
   logic [7:0] dsep_q;
   always_ff @(posedge clk) begin
      if (reset)                              dsep_q <= DSEP;
      else if (accept && cnt == 5'd0)         dsep_q <= xof ? XOF_DSEP : DSEP;
   end
   assign dsep_eff = (cnt == 5'd0) ? (xof ? XOF_DSEP : DSEP) : dsep_q;
`else
   assign dsep_eff = DSEP;
`endif

   assign rate_eff   = (cnt == 5'd0) ? rate_sel : rate_q;
   assign accept     = in_ready && (state_q == FILL);
   assign cnt_inc    = cnt + 5'd1;
   assign block_done = accept && (is_last || cnt_inc == rate_eff);

   // Final word keeps byte_num leading bytes, then the domain byte, then zeros
   assign keep_mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> {byte_num, 3'b000});
   assign last_word = (in & keep_mask) | ({56'd0, dsep_eff} << (6'd56 - {byte_num, 3'b000}));

   always_ff @(posedge clk) begin
      if (reset) state_q <= FILL;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL:    if (block_done) state_d = FULL;
         FULL:    if (f_ack)      state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   // Next block contents: store the word, zero the tail and set the closing 0x80 on a last word
   always_comb begin
      for (int i = 0; i < MAX_WORDS; i++) begin
         blk_d[i] = blk[i];
         if (accept) begin
            if (5'(i) == cnt)                blk_d[i] = is_last ? last_word : in;
            else if (is_last && 5'(i) > cnt) blk_d[i] = '0;
            if (is_last && 5'(i) == rate_eff - 5'd1)
               blk_d[i][7:0] = blk_d[i][7:0] | 8'h80;
         end else if (state_q == FULL && f_ack) begin
            blk_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MAX_WORDS; i++) blk[i] <= '0;
      end else begin
         blk <= blk_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         rate_q   <= 5'd9;
         out_last <= 1'b0;
      end else if (accept) begin
         if (cnt == 5'd0) rate_q <= rate_sel;
         cnt <= block_done ? 5'd0 : cnt_inc;
         if (block_done) out_last <= is_last;
      end else if (state_q == FULL && f_ack) begin
         out_last <= 1'b0;
      end
   end

   assign buffer_full = (state_q == FULL);
   assign out_ready   = buffer_full;

   for (genvar g = 0; g < OUT_WORDS; g++) begin : g_out
      if (g < MAX_WORDS) begin : g_word
         assign out[1343-64*g -: 64] = blk[g];
      end else begin : g_zero
         assign out[1343-64*g -: 64] = '0;
      end
   end
endmodule
